arbitro_carga_ram: RTL and testbench
====================================

# arbitro_carga_ram

Program-loader sequencer and RAM-port arbiter for the SAP-1 core. It owns the single port of the 16×8 program RAM and hands it to one of two masters. In program mode, a debounced front-panel WR button writes `ram_dip` to address `mar_dip`. In run mode, the core's memory requests pass through. It sits between the front-panel inputs, the core's memory interface and `memoria_ram`. It also drives a hold signal that freezes the core while programming.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required for a button press and for a release. Legal range is 2..255.
- `clock`, in, 1: single system clock. All state updates on the rising edge.
- `clear`, in, 1: asynchronous, active-high reset.
- `prog_run`, in, 1: front-panel switch, asynchronous. 0 = program mode, 1 = run mode.
- `wr_button`, in, 1: raw WR push-button, asynchronous, active-high.
- `mar_dip`, in, 4: program-mode address switches.
- `ram_dip`, in, 8: program-mode data switches.
- `cpu_req`, in, 1: core memory request, valid for one cycle.
- `cpu_we`, in, 1: request is a write when 1.
- `cpu_addr`, in, 4: core address.
- `cpu_wdata`, in, 8: core write data.
- `cpu_gnt`, out, 1: request accepted this cycle.
- `cpu_rvalid`, out, 1: read data valid.
- `cpu_rdata`, out, 8: read data.
- `cpu_hold`, out, 1: core clock-enable low (core frozen).
- `ram_addr`, out, 4: RAM address.
- `ram_wdata`, out, 8: RAM write data.
- `ram_we`, out, 1: RAM write strobe.
- `ram_rdata`, in, 8: RAM read data. Valid one cycle after the address is presented.
- `wr_ack`, out, 1: one-cycle pulse on each loader write (panel LED).
- `load_count`, out, 5: loader writes since program mode was entered. Saturates at 31.

## Operation
- **Synchronisers.** `prog_run` and `wr_button` each pass through a 2-flop synchroniser, giving `run_s` and `btn_s`. Both synchronisers reset to 0.
- **State machine.** States are PROG, DEB, WRITE, REL, RUN and DRAIN. Reset state is PROG.
- **RUN**
  - Outputs: `cpu_hold`=0.
  - `cpu_gnt` = `cpu_req` (combinational).
  - `ram_addr`/`ram_wdata` = `cpu_addr`/`cpu_wdata`.
  - `ram_we` = `cpu_req & cpu_we`.
  - A granted read sets `cpu_rvalid`=1 in the next cycle, with `cpu_rdata` = `ram_rdata`.
  - Transition: `run_s`=0 moves to DRAIN.
- **DRAIN** (exactly 1 cycle)
  - Outputs: `cpu_hold`=1, `cpu_gnt`=0, `ram_we`=0.
  - A read granted in the last RUN cycle still returns its `cpu_rvalid` here.
  - Transition: always to PROG. On this transition `load_count` clears to 0.
- **PROG**
  - Outputs: `cpu_hold`=1, `cpu_gnt`=0.
  - `ram_addr` = `mar_dip`, so the RAM output shows the selected byte.
  - Transitions: `run_s`=1 moves to RUN; otherwise `btn_s`=1 moves to DEB with counter = 0.
- **DEB**
  - Counter increments each cycle while `btn_s`=1.
  - Transitions, in priority order:
    - `btn_s`=0 returns to PROG (glitch rejected, no write).
    - `run_s`=1 moves to RUN.
    - Counter = `DEBOUNCE_CYCLES`-1 moves to WRITE.
- **WRITE** (exactly 1 cycle)
  - Outputs: `ram_we`=1, `ram_addr`=`mar_dip`, `ram_wdata`=`ram_dip` (values in this cycle).
  - `wr_ack`=1 and `load_count` increments (saturating at 31).
  - Transition: always to REL, with counter = 0. `run_s` is ignored in this cycle.
- **REL**
  - Counter counts consecutive cycles with `btn_s`=0 and restarts at 0 whenever `btn_s`=1.
  - Transitions: counter = `DEBOUNCE_CYCLES`-1 returns to PROG; `run_s`=1 moves to RUN.
  - One press therefore produces exactly one write, however long the button is held.
- **Outputs in every state other than RUN**
  - `cpu_gnt`=0.
  - A `cpu_req` arriving then is dropped with no side effect; the core is held, so this is not a legal request.
- **Reset** (`clear`=1, asynchronous)
  - State goes to PROG; counter, `load_count` and synchronisers go to 0.
  - Outputs while `clear`=1: `cpu_hold`=1; `cpu_gnt`=0, `cpu_rvalid`=0, `ram_we`=0, `wr_ack`=0, `load_count`=0.
  - A reset in WRITE aborts the write: `ram_we` falls immediately and `load_count` stays 0.

## Timing
- **Mode-switch latency.**
  - `prog_run` rising: `cpu_hold` falls 3 rising edges after the first edge sampling it high (2 synchroniser edges plus 1 FSM edge).
  - `prog_run` falling: `cpu_hold` rises 3 edges after the first edge sampling it low (entry to DRAIN). PROG is reached 1 edge later.
- **Write latency.** `ram_we` is high for exactly one cycle, starting `DEBOUNCE_CYCLES`+2 edges after the first edge that samples `wr_button` high. This requires the button to stay high throughout.
- **Core port.** Grant is zero-latency. Read data returns 1 cycle after the grant, and there is no back-pressure in RUN.
- **Single driver.** `ram_we` is never asserted by both masters in the same cycle; the RAM port always has exactly one driver.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset in run mode.** Hold `clear` with `prog_run`=1, then release. Required: `cpu_hold`=1, `load_count`=0 at release; `cpu_hold`=0 after the 3rd edge.
- **Clean write.** In PROG with `mar_dip`=4'hA and `ram_dip`=8'h5C, press `wr_button` for 20 cycles. Required:
  - One `ram_we`/`wr_ack` pulse 6 edges after the first high sample, at address A with data 5C.
  - `load_count`=1; no second write while the button is held.
- **Glitch rejection.** Pulse `wr_button` high for 3 cycles. Required: no `ram_we`, and `load_count` is unchanged.
- **Release bounce.** After a write, toggle the button 0/1 every 2 cycles for 10 cycles, then hold it low. Required: no extra write; PROG is re-entered 4 stable-low cycles after the last high sample.
- **Core read/write.** In RUN, write 8'h33 to address 2, then read address 2. Required:
  - `cpu_gnt`=1 in both request cycles, and `ram_we`=1 in the write cycle only.
  - `cpu_rvalid`=1 with `cpu_rdata`=8'h33 one cycle after the read grant.
- **Switch with read in flight.** Issue a read in the same cycle that the synchronised `run_s` falls. Required:
  - The read's `cpu_rvalid` appears in DRAIN.
  - No grant after `cpu_hold`=1, and `load_count` reads 0 on entering PROG.

Source files
------------

// File: rtl/arbitro_carga_ram.sv
// Program-loader sequencer and RAM-port arbiter for the SAP-1 core.
// Owns the single 16x8 RAM port: front panel in program mode, core in run mode.
module arbitro_carga_ram #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       prog_run,
    input  logic       wr_button,
    input  logic [3:0] mar_dip,
    input  logic [7:0] ram_dip,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       cpu_hold,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata,
    output logic       wr_ack,
    output logic [4:0] load_count
);

    localparam logic [2:0] S_PROG  = 3'd0;
    localparam logic [2:0] S_DEB   = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_REL   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] run_sync_q;
    logic [1:0] btn_sync_q;
    logic       run_s;
    logic       btn_s;

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] load_q, load_d;
    logic       rvalid_q, rvalid_d;

    assign run_s = run_sync_q[1];
    assign btn_s = btn_sync_q[1];

    // Two-flop synchronisers for the asynchronous panel inputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            run_sync_q <= 2'b00;
            btn_sync_q <= 2'b00;
        end else begin
            run_sync_q <= {run_sync_q[0], prog_run};
            btn_sync_q <= {btn_sync_q[0], wr_button};
        end
    end

    // Sequencer state, debounce counter, loader count and read-valid flag
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_PROG;
            cnt_q    <= 8'd0;
            load_q   <= 5'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic: debounce press, single write, debounce release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        unique case (state_q)
            S_PROG: begin
                if (run_s) begin
                    state_d = S_RUN;
                end else if (btn_s) begin
                    state_d = S_DEB;
                    cnt_d   = 8'd0;
                end
            end
            S_DEB: begin
                if (!btn_s) begin
                    state_d = S_PROG;
                end else if (run_s) begin
                    state_d = S_RUN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                state_d = S_REL;
                cnt_d   = 8'd0;
                load_d  = (load_q == 5'd31) ? load_q : load_q + 5'd1;
            end
            S_REL: begin
                if (run_s) begin
                    state_d = S_RUN;
                end else if (btn_s) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PROG;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (!run_s) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_PROG;
                load_d  = 5'd0;
            end
            default: begin
                state_d = S_PROG;
            end
        endcase
    end

    // RAM port mux and core handshake; core is held outside RUN
    always_comb begin
        cpu_hold  = 1'b1;
        cpu_gnt   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = mar_dip;
        ram_wdata = ram_dip;
        wr_ack    = 1'b0;
        rvalid_d  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                cpu_hold  = 1'b0;
                cpu_gnt   = cpu_req;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_req & cpu_we;
                rvalid_d  = cpu_req & ~cpu_we;
            end
            S_WRITE: begin
                ram_we = 1'b1;
                wr_ack = 1'b1;
            end
            default: begin
                cpu_hold = 1'b1;
            end
        endcase
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = ram_rdata;
    assign load_count = load_q;

endmodule

// File: tb/tb_arbitro_carga_ram.sv
// Directed bench for arbitro_carga_ram with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_arbitro_carga_ram;

    logic       clock = 1'b0;
    logic       clear;
    logic       prog_run;
    logic       wr_button;
    logic [3:0] mar_dip;
    logic [7:0] ram_dip;
    logic       cpu_req;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       cpu_hold;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic       wr_ack;
    logic [4:0] load_count;

    logic [7:0] mem [16];
    int         we_cnt = 0;
    int         viol = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         base;

    arbitro_carga_ram #(.DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .clear      (clear),
        .prog_run   (prog_run),
        .wr_button  (wr_button),
        .mar_dip    (mar_dip),
        .ram_dip    (ram_dip),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .wr_ack     (wr_ack),
        .load_count (load_count)
    );

    always #5 clock = ~clock;

    // Synchronous 16x8 RAM with one-cycle read latency
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Count write strobes and grants issued while the core is held
    always @(posedge clock) begin
        if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
        if (cpu_gnt === 1'b1 && cpu_hold === 1'b1) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic core(input logic req, input logic we,
                        input logic [3:0] a, input logic [7:0] d);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
    endtask

    initial begin
        clear     = 1'b1;
        prog_run  = 1'b1;
        wr_button = 1'b0;
        mar_dip   = 4'h0;
        ram_dip   = 8'h00;
        core(1'b1, 1'b0, 4'h0, 8'h00);

        // Reset held in run mode
        nedge(3);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_gnt", cpu_gnt, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_load", load_count, 0);
        core(1'b0, 1'b0, 4'h0, 8'h00);
        clear = 1'b0;
        nedge(1);
        chk("run_lat_e1", cpu_hold, 1);
        nedge(1);
        chk("run_lat_e2", cpu_hold, 1);
        nedge(1);
        chk("run_lat_e3", cpu_hold, 0);

        // Core write then read of address 2
        core(1'b1, 1'b1, 4'h2, 8'h33);
        chk("cw_gnt", cpu_gnt, 1);
        chk("cw_we", ram_we, 1);
        chk("cw_addr", ram_addr, 4'h2);
        nedge(1);
        core(1'b1, 1'b0, 4'h2, 8'h00);
        chk("cr_gnt", cpu_gnt, 1);
        chk("cr_we", ram_we, 0);
        chk("cr_rv0", cpu_rvalid, 0);
        nedge(1);
        core(1'b0, 1'b0, 4'h0, 8'h00);
        chk("cr_rv1", cpu_rvalid, 1);
        chk("cr_data", cpu_rdata, 8'h33);
        nedge(1);
        chk("cr_rv2", cpu_rvalid, 0);

        // Plain switch back to program mode
        prog_run = 1'b0;
        nedge(2);
        chk("prog_lat_e2", cpu_hold, 0);
        nedge(1);
        chk("prog_lat_e3", cpu_hold, 1);
        nedge(1);

        // Clean write held 20 cycles: single pulse 6 edges after first sample
        mar_dip   = 4'hA;
        ram_dip   = 8'h5C;
        base      = we_cnt;
        wr_button = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            nedge(1);
            chk($sformatf("cw_we_%0d", i), ram_we, (i == 7));
            chk($sformatf("cw_ack_%0d", i), wr_ack, (i == 7));
            if (i == 7) begin
                chk("cw_waddr", ram_addr, 4'hA);
                chk("cw_wdata", ram_wdata, 8'h5C);
                chk("cw_load_pre", load_count, 0);
            end
        end
        chk("cw_load", load_count, 1);
        chk("cw_count", we_cnt - base, 1);

        // Release bounce, then a re-press timed to the first PROG cycle
        mar_dip = 4'h3;
        ram_dip = 8'hC3;
        base    = we_cnt;
        for (int k = 0; k <= 24; k++) begin
            if (k < 10) wr_button = ((k / 2) % 2) == 1;
            else        wr_button = (k >= 12);
            chk($sformatf("rb_we_%0d", k), ram_we, (k == 19));
            if (k == 19) begin
                chk("rb_waddr", ram_addr, 4'h3);
                chk("rb_wdata", ram_wdata, 8'hC3);
            end
            nedge(1);
        end
        chk("rb_load", load_count, 2);
        chk("rb_count", we_cnt - base, 1);
        wr_button = 1'b0;
        nedge(10);

        // Three-cycle glitch is rejected
        base      = we_cnt;
        wr_button = 1'b1;
        nedge(3);
        wr_button = 1'b0;
        nedge(12);
        chk("gl_count", we_cnt - base, 0);
        chk("gl_load", load_count, 2);

        // Back to run mode and read back the loaded bytes
        prog_run = 1'b1;
        nedge(3);
        chk("run2_hold", cpu_hold, 0);
        core(1'b1, 1'b0, 4'hA, 8'h00);
        chk("rd_a_gnt", cpu_gnt, 1);
        nedge(1);
        core(1'b1, 1'b0, 4'h3, 8'h00);
        chk("rd_a_rv", cpu_rvalid, 1);
        chk("rd_a_data", cpu_rdata, 8'h5C);
        nedge(1);
        core(1'b0, 1'b0, 4'h0, 8'h00);
        chk("rd_3_rv", cpu_rvalid, 1);
        chk("rd_3_data", cpu_rdata, 8'hC3);
        chk("run2_load", load_count, 2);

        // Read issued in the cycle run_s falls completes in DRAIN
        prog_run = 1'b0;
        nedge(2);
        core(1'b1, 1'b0, 4'hA, 8'h00);
        chk("fl_gnt", cpu_gnt, 1);
        chk("fl_hold0", cpu_hold, 0);
        nedge(1);
        core(1'b1, 1'b0, 4'h2, 8'h00);
        chk("dr_hold", cpu_hold, 1);
        chk("dr_gnt", cpu_gnt, 0);
        chk("dr_we", ram_we, 0);
        chk("dr_rv", cpu_rvalid, 1);
        chk("dr_data", cpu_rdata, 8'h5C);
        chk("dr_load", load_count, 2);
        nedge(1);
        core(1'b0, 1'b0, 4'h0, 8'h00);
        chk("pg_hold", cpu_hold, 1);
        chk("pg_gnt", cpu_gnt, 0);
        chk("pg_rv", cpu_rvalid, 0);
        chk("pg_load", load_count, 0);
        chk("held_gnt", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
